// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return, interrupt pending logic and cycle/instret counters.
// Define CSR_INSTRET_EN to build minstret/minstreth (0xB02/0xB82); otherwise those addresses are illegal.
module csr_trap_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MVENDORID   = 32'h0131_09F5,
   parameter int unsigned CNT_WIDTH   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_en,
   input  logic [1:0]  csr_op,
   input  logic        csr_nowr,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata_o,
   output logic        illegal_o,
   input  logic        retire,
   input  logic        trap_valid,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   input  logic        irq_ext,
   input  logic        irq_timer,
   output logic        irq_pending_o,
   output logic [31:0] trap_vector_o,
   output logic [31:0] mepc_o
);

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;

   logic                 mstatus_mie_q, mstatus_mie_d;
   logic                 mstatus_mpie_q, mstatus_mpie_d;
   logic                 mie_meie_q, mie_meie_d;
   logic                 mie_mtie_q, mie_mtie_d;
   logic                 mip_meip_q, mip_mtip_q;
   logic [31:0]          mtvec_q, mtvec_d;
   logic [31:0]          mscratch_q, mscratch_d;
   logic [31:0]          mepc_q, mepc_d;
   logic [31:0]          mcause_q, mcause_d;
   logic [31:0]          mtval_q, mtval_d;
   logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
   logic [63:0]          cyc64;

   logic        implemented;
   logic        wr_attempt;
   logic        illegal;
   logic        wr_en;
   logic [31:0] old_val;
   logic [31:0] new_val;
   logic [31:0] vec_base;

   assign cyc64 = 64'(mcycle_q);

`ifdef CSR_INSTRET_EN
   logic [CNT_WIDTH-1:0] minstret_q, minstret_d;
   logic [63:0]          ret64;
   assign ret64 = 64'(minstret_q);
`else
   logic unused_retire;
   assign unused_retire = retire;
`endif

   // Read mux and address decode; old_val is the pre-write value seen by RS/RC.
   always_comb begin
      implemented = 1'b1;
      old_val     = '0;
      case (csr_addr)
         12'h300: old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         12'h301: old_val = 32'h4000_0100;
         12'h304: old_val = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
         12'h305: old_val = mtvec_q;
         12'h340: old_val = mscratch_q;
         12'h341: old_val = mepc_q;
         12'h342: old_val = mcause_q;
         12'h343: old_val = mtval_q;
         12'h344: old_val = {20'b0, mip_meip_q, 3'b0, mip_mtip_q, 7'b0};
         12'hB00: old_val = cyc64[31:0];
         12'hB80: old_val = cyc64[63:32];
`ifdef CSR_INSTRET_EN
         12'hB02: old_val = ret64[31:0];
         12'hB82: old_val = ret64[63:32];
`endif
         12'hF11: old_val = MVENDORID;
         default: implemented = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_op)
         OP_RW:   new_val = csr_wdata;
         OP_RS:   new_val = old_val | csr_wdata;
         default: new_val = old_val & ~csr_wdata;
      endcase
   end

   assign wr_attempt  = (csr_op != OP_NONE) && !csr_nowr;
   assign illegal     = csr_en && (!implemented || (csr_op == OP_NONE) ||
                                   ((csr_addr[11:10] == 2'b11) && wr_attempt));
   // Trap and mret both pre-empt a same-cycle CSR write.
   assign wr_en       = csr_en && !illegal && wr_attempt && !trap_valid && !mret;
   assign illegal_o   = illegal;
   assign csr_rdata_o = (csr_en && !illegal) ? old_val : 32'h0;

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_meie_d     = mie_meie_q;
      mie_mtie_d     = mie_mtie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mcycle_d       = mcycle_q + CNT_WIDTH'(1);
`ifdef CSR_INSTRET_EN
      minstret_d     = retire ? minstret_q + CNT_WIDTH'(1) : minstret_q;
`endif
      if (trap_valid) begin
         mepc_d         = trap_pc & ~32'h3;
         mcause_d       = trap_cause;
         mtval_d        = trap_tval;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (wr_en) begin
         case (csr_addr)
            12'h300: begin
               mstatus_mie_d  = new_val[3];
               mstatus_mpie_d = new_val[7];
            end
            12'h304: begin
               mie_meie_d = new_val[11];
               mie_mtie_d = new_val[7];
            end
            12'h305: mtvec_d    = new_val & ~32'h2;
            12'h340: mscratch_d = new_val;
            12'h341: mepc_d     = new_val & ~32'h3;
            12'h342: mcause_d   = new_val;
            12'h343: mtval_d    = new_val;
            12'hB00: mcycle_d   = CNT_WIDTH'({cyc64[63:32], new_val});
            12'hB80: mcycle_d   = CNT_WIDTH'({new_val, cyc64[31:0]});
`ifdef CSR_INSTRET_EN
            12'hB02: minstret_d = CNT_WIDTH'({ret64[63:32], new_val});
            12'hB82: minstret_d = CNT_WIDTH'({new_val, ret64[31:0]});
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_meie_q     <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mip_meip_q     <= 1'b0;
         mip_mtip_q     <= 1'b0;
         mtvec_q        <= MTVEC_RESET & ~32'h2;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
`ifdef CSR_INSTRET_EN
         minstret_q     <= '0;
`endif
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_meie_q     <= mie_meie_d;
         mie_mtie_q     <= mie_mtie_d;
         mip_meip_q     <= irq_ext;
         mip_mtip_q     <= irq_timer;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mcycle_q       <= mcycle_d;
`ifdef CSR_INSTRET_EN
         minstret_q     <= minstret_d;
`endif
      end
   end

   assign irq_pending_o = mstatus_mie_q & ((mip_meip_q & mie_meie_q) | (mip_mtip_q & mie_mtie_q));

   // Vectored mode offsets only asynchronous causes (interrupts).
   assign vec_base      = {mtvec_q[31:2], 2'b00};
   assign trap_vector_o = (mtvec_q[0] && trap_cause[31]) ?
                          vec_base + {25'b0, trap_cause[4:0], 2'b00} : vec_base;
   assign mepc_o        = mepc_q;

endmodule
